// File: rtl/servo_pkg.sv
// Shared constants for the servo position sweep.
// Default timing targets a 50 MHz clock and a 20 ms servo frame.
package servo_pkg;

  localparam int SERVO_PERIOD     = 1000000;
  localparam int SERVO_WIDTH_MIN  = 50000;
  localparam int SERVO_WIDTH_STEP = 7000;
  localparam int SERVO_HOLD       = 25;
  localparam int SERVO_CW         = 20;
  localparam int POS_W            = 3;

endpackage

// File: rtl/contador_m.sv
// Generic modulo-M counter with synchronous clear.
// fim flags the terminal count M-1.
module contador_m #(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q,
  output logic         fim
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (conta) begin
      q_d = (q_q == N'(M - 1)) ? '0 : q_q + N'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (zera) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q   = q_q;
  assign fim = (q_q == N'(M - 1));

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Servo PWM generator: fixed period, width linear in position index.
// Emits conta_pos every HOLD active periods to step the selector.
module servo_pwm_ctrl
  import servo_pkg::*;
#(
  parameter int PERIOD     = SERVO_PERIOD,
  parameter int WIDTH_MIN  = SERVO_WIDTH_MIN,
  parameter int WIDTH_STEP = SERVO_WIDTH_STEP,
  parameter int HOLD       = SERVO_HOLD,
  parameter int CW         = SERVO_CW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             liga,
  input  logic [POS_W-1:0] posicao,
  output logic             pwm,
  output logic             fim_periodo,
  output logic             conta_pos,
  output logic [POS_W-1:0] db_posicao
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  if ((WIDTH_MIN + 7 * WIDTH_STEP > PERIOD) || (HOLD < 1) ||
      (PERIOD < 2) || ((PERIOD - 1) >= (2 ** CW))) begin : g_bad_cfg
    $fatal(1, "servo_pwm_ctrl: invalid parameter set");
  end

  logic [CW-1:0]    cnt;
  logic             fim;
  logic [CW-1:0]    cnt_nx;
  logic [CW-1:0]    nova_largura;
  logic [CW-1:0]    largura_q, largura_d;
  logic             ativo_q, ativo_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             pwm_q, pwm_d;

  contador_m #(
    .M (PERIOD),
    .N (CW)
  ) u_periodo (
    .clock (clock),
    .zera  (reset),
    .conta (1'b1),
    .q     (cnt),
    .fim   (fim)
  );

  assign nova_largura = CW'(WIDTH_MIN) + CW'(posicao) * CW'(WIDTH_STEP);
  assign cnt_nx       = cnt + CW'(1);

  // pwm_d looks one cycle ahead so the registered pulse lines up with cnt
  always_comb begin
    largura_d = largura_q;
    ativo_d   = ativo_q;
    pos_d     = pos_q;
    hold_d    = hold_q;
    pwm_d     = ativo_q && (cnt_nx < largura_q);
    if (fim) begin
      largura_d = nova_largura;
      ativo_d   = liga;
      pos_d     = posicao;
      pwm_d     = liga && (nova_largura != '0);
      if (!ativo_q || hold_q == HOLD_LAST) hold_d = '0;
      else                                 hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      largura_q <= CW'(WIDTH_MIN);
      ativo_q   <= 1'b0;
      pos_q     <= '0;
      hold_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      largura_q <= largura_d;
      ativo_q   <= ativo_d;
      pos_q     <= pos_d;
      hold_q    <= hold_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm         = pwm_q;
  assign fim_periodo = fim;
  assign conta_pos   = fim && ativo_q && (hold_q == HOLD_LAST);
  assign db_posicao  = pos_q;

endmodule

// File: doc/servo_pwm_ctrl.md
Name: servo_pwm_ctrl

Overview:
Downstream stage of the servo position sweep. Takes the 3-bit position index from the position selector and generates a fixed-period servo PWM signal. The pulse width is linear in the index. The block also emits the advance strobe that steps the selector every HOLD periods, which closes the sweep loop. It sits between the selector and the servo output pin.

Parameters:
PERIOD, 1000000, PWM period in clock cycles (20 ms at 50 MHz)
WIDTH_MIN, 50000, pulse width in cycles for position 0 (1 ms)
WIDTH_STEP, 7000, extra cycles per position increment (position 7 = 99000)
HOLD, 25, number of full periods each position is held before conta_pos fires
CW, 20, counter/width register bits; must satisfy PERIOD-1 < 2^CW

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
liga  input  1  enable; sampled only at period boundaries
posicao  input  3  position index from the selector (0..7)
pwm  output  1  servo control pulse
fim_periodo  output  1  one-cycle strobe in the last cycle of each period
conta_pos  output  1  one-cycle advance strobe to the selector's conta input
db_posicao  output  3  position currently applied (latched copy)

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clock.
- Reset values:
  - cnt = 0, hold_cnt = 0, ativo = 0.
  - largura = WIDTH_MIN, db_posicao = 0.
  - pwm = 0, fim_periodo = 0, conta_pos = 0.
- Period counter cnt:
  - Counts 0..PERIOD-1 every cycle and wraps to 0.
  - fim_periodo = 1 exactly when cnt == PERIOD-1.
- Boundary edge (cnt PERIOD-1 -> 0):
  - largura <= WIDTH_MIN + posicao*WIDTH_STEP, computed at CW bits.
  - db_posicao <= posicao.
  - ativo <= liga.
- posicao or liga changes mid-period have no effect until the next boundary. This guarantees glitch-free pulses.
- pwm is registered and is 1 in every cycle where ativo == 1 and cnt < largura. It rises in the cnt == 0 cycle and is high for exactly largura cycles per period.
- After reset, ativo = 0, so the first period is entirely low. Output begins in the period after the first boundary at which liga = 1.
- hold_cnt (0..HOLD-1):
  - At each boundary with ativo == 1, it increments.
  - conta_pos = 1 in the cnt == PERIOD-1 cycle when ativo == 1 and hold_cnt == HOLD-1; hold_cnt wraps to 0 at that boundary.
  - At a boundary with ativo == 0, hold_cnt is cleared to 0 and conta_pos stays 0.
- liga dropped mid-pulse: the current pulse completes normally; the next period is low.
- reset mid-pulse: the next cycle has pwm = 0, cnt = 0, ativo = 0; all strobes are low.
- Elaboration check: fail if WIDTH_MIN + 7*WIDTH_STEP > PERIOD, or if HOLD < 1.

Decomposition:
- Shared package servo_pkg holds:
  - constants: SERVO_PERIOD, SERVO_WIDTH_MIN, SERVO_WIDTH_STEP, SERVO_HOLD, SERVO_CW
  - POS_W = 3
- The period counter is an instance of the existing generic modulo counter contador_m (M = PERIOD, N = CW); its fim output provides fim_periodo.
- Width latch, enable latch, hold counter and pwm compare stay in servo_pwm_ctrl.

Test Plan:
Bench parameters: PERIOD=20, WIDTH_MIN=4, WIDTH_STEP=2, HOLD=3, CW=5.
1. reset high for 3 cycles, then liga=1, posicao=0 -> all outputs 0 during reset; pwm low for the whole first period; then pwm high at cnt 0..3 of each period (4 of 20 cycles).
2. posicao=7 applied before a boundary -> pwm high 18 cycles per period; db_posicao = 7 from the cnt == 0 cycle.
3. posicao=2 for the current period, changed to 6 at cnt=5 -> current pulse stays 8 cycles; next period pulse is 16 cycles; db_posicao changes only at the boundary.
4. liga=1 steady -> fim_periodo pulses every 20 cycles; conta_pos pulses on every 3rd fim_periodo only, coincident with it, one cycle wide.
5. liga=0 at cnt=2 with width 8 -> current pulse completes its 8 cycles; following period pwm = 0 and conta_pos = 0. Re-assert liga -> first conta_pos appears after 3 full active periods.
6. reset asserted at cnt=3 while pwm=1 -> next cycle pwm=0, cnt=0, db_posicao=0, strobes 0; the period after release is low.
